// File: rtl/poly_horner_solver_if.sv
// Handshake and data bundle for poly_horner_solver: request side (enable, x, coeffs)
// and result side (y, ready, valid, overflow).
interface poly_horner_solver_if #(
    parameter int XW     = 8,
    parameter int CW     = 16,
    parameter int YW     = 16,
    parameter int DEGREE = 2
);
    logic                         enable;
    logic signed [XW-1:0]         x;
    logic [(DEGREE+1)*CW-1:0]     coeffs;
    logic signed [YW-1:0]         y;
    logic                         ready;
    logic                         valid;
    logic                         overflow;

    modport master (
        output enable, x, coeffs,
        input  y, ready, valid, overflow
    );

    modport slave (
        input  enable, x, coeffs,
        output y, ready, valid, overflow
    );
endinterface

// File: rtl/poly_horner_solver.sv
// Signed polynomial evaluator using Horner's method: one multiply-add per clock,
// wrap or clamp on overflow, sticky overflow flag per request.
module poly_horner_solver #(
    parameter int XW       = 8,
    parameter int CW       = 16,
    parameter int YW       = 16,
    parameter int DEGREE   = 2,
    parameter int SATURATE = 0
) (
    input logic                 clock,
    input logic                 reset,
    poly_horner_solver_if.slave bus
);
    localparam int CNTW = $clog2(DEGREE + 1);
    localparam int NK   = 1 << CNTW;
    localparam int PW   = (YW + XW > CW) ? (YW + XW) : CW;
    localparam int EW   = PW + 1;
    localparam logic [YW-1:0] YMAX = {1'b0, {(YW-1){1'b1}}};
    localparam logic [YW-1:0] YMIN = {1'b1, {(YW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    logic signed [XW-1:0]   xr;
    logic signed [CW-1:0]   kin [NK];
    logic signed [CW-1:0]   kr  [NK];
    logic signed [YW-1:0]   acc;
    logic [CNTW-1:0]        cnt;
    logic                   sticky;
    logic signed [YW-1:0]   y_r;
    logic                   valid_r;
    logic                   ovf_r;

    logic signed [EW-1:0]   ax, xx, kx, exact, kd;
    logic [YW:0]            step_fit, init_fit;

    // Reduce an exact value to YW bits; MSB of the result flags out-of-range.
    function automatic logic [YW:0] fit(input logic signed [EW-1:0] v);
        logic [EW-YW:0] top;
        top = v[EW-1:YW-1];
        if ((&top) || (~|top))
            return {1'b0, v[YW-1:0]};
        else if (SATURATE != 0)
            return {1'b1, (v[EW-1] ? YMIN : YMAX)};
        else
            return {1'b1, v[YW-1:0]};
    endfunction

    always_comb begin
        kin = '{default: '0};
        for (int unsigned i = 0; i <= DEGREE; i++)
            kin[CNTW'(i)] = bus.coeffs[i*CW +: CW];
    end

    always_comb begin
        ax       = EW'(acc);
        xx       = EW'(xr);
        kx       = EW'(kr[cnt]);
        exact    = ax * xx + kx;
        kd       = EW'(kin[DEGREE]);
        step_fit = fit(exact);
        init_fit = fit(kd);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (bus.enable) state_nx = BUSY;
            BUSY:       if (cnt == '0) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xr      <= '0;
            kr      <= '{default: '0};
            acc     <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            y_r     <= '0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.enable) begin
                        xr      <= bus.x;
                        kr      <= kin;
                        acc     <= init_fit[YW-1:0];
                        sticky  <= init_fit[YW];
                        cnt     <= CNTW'(DEGREE - 1);
                        valid_r <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                BUSY: begin
                    acc    <= step_fit[YW-1:0];
                    sticky <= sticky | step_fit[YW];
                    cnt    <= cnt - CNTW'(1);
                    // The last step's result goes straight to y so valid lands DEGREE edges after accept.
                    if (cnt == '0) begin
                        y_r     <= step_fit[YW-1:0];
                        valid_r <= 1'b1;
                        ovf_r   <= sticky | step_fit[YW];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y        = y_r;
    assign bus.valid    = valid_r;
    assign bus.overflow = ovf_r;
    assign bus.ready    = (state != BUSY);
endmodule

// File: tb/tb_poly_horner_solver.sv
// Directed bench for poly_horner_solver: wrapping and saturating DEGREE=2 instances
// plus a DEGREE=3 instance, sharing clock and reset.
module tb_poly_horner_solver;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    poly_horner_solver_if #(.XW(8), .CW(16), .YW(16), .DEGREE(2)) bw ();
    poly_horner_solver_if #(.XW(8), .CW(16), .YW(16), .DEGREE(2)) bs ();
    poly_horner_solver_if #(.XW(8), .CW(16), .YW(16), .DEGREE(3)) b3 ();

    poly_horner_solver #(.XW(8), .CW(16), .YW(16), .DEGREE(2), .SATURATE(0))
        dut_wrap (.clock(clock), .reset(reset), .bus(bw));
    poly_horner_solver #(.XW(8), .CW(16), .YW(16), .DEGREE(2), .SATURATE(1))
        dut_sat (.clock(clock), .reset(reset), .bus(bs));
    poly_horner_solver #(.XW(8), .CW(16), .YW(16), .DEGREE(3), .SATURATE(0))
        dut_d3 (.clock(clock), .reset(reset), .bus(b3));

    function automatic logic [47:0] pk3(input int k2, input int k1, input int k0);
        logic [47:0] r;
        r = {k2[15:0], k1[15:0], k0[15:0]};
        return r;
    endfunction

    function automatic logic [63:0] pk4(input int k3, input int k2, input int k1, input int k0);
        logic [63:0] r;
        r = {k3[15:0], k2[15:0], k1[15:0], k0[15:0]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bw.enable = 1'b0; bw.x = '0; bw.coeffs = '0;
        bs.enable = 1'b0; bs.x = '0; bs.coeffs = '0;
        b3.enable = 1'b0; b3.x = '0; b3.coeffs = '0;
        tick(); tick();
        checks++;
        if (bw.y !== 16'sd0 || bw.valid !== 1'b0 || bw.ready !== 1'b1 || bw.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got y=%0d v=%b r=%b o=%b want y=0 v=0 r=1 o=0",
                     $signed(bw.y), bw.valid, bw.ready, bw.overflow);
        end
        checks++;
        if (b3.ready !== 1'b1 || b3.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_d3 got r=%b v=%b want r=1 v=0", b3.ready, b3.valid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        bw.x = 8'sd3; bw.coeffs = pk3(2, -5, 7); bw.enable = 1'b1;
        tick();
        bw.enable = 1'b0;
        checks++;
        if (bw.ready !== 1'b0 || bw.valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got r=%b v=%b want r=0 v=0", bw.ready, bw.valid);
        end
        n = 0;
        while (!bw.valid && n < 20) begin tick(); n++; end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL basic_latency got %0d edges want 2", n);
        end
        checks++;
        if (bw.y !== 16'sd10 || bw.overflow !== 1'b0 || bw.ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_result got y=%0d o=%b r=%b want y=10 o=0 r=1",
                     $signed(bw.y), bw.overflow, bw.ready);
        end
    endtask

    task automatic test_overflow();
        int n;
        bw.x = 8'sd127; bw.coeffs = pk3(100, 0, 0); bw.enable = 1'b1;
        bs.x = 8'sd127; bs.coeffs = pk3(100, 0, 0); bs.enable = 1'b1;
        tick();
        bw.enable = 1'b0; bs.enable = 1'b0;
        n = 0;
        while (!bw.valid && n < 20) begin tick(); n++; end
        checks++;
        if (bw.y !== -16'sd25500 || bw.overflow !== 1'b1 || n !== 2) begin
            errors++;
            $display("FAIL wrap_result got y=%0d o=%b n=%0d want y=-25500 o=1 n=2",
                     $signed(bw.y), bw.overflow, n);
        end
        checks++;
        if (bs.valid !== 1'b1 || bs.y !== 16'sd32767 || bs.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got v=%b y=%0d o=%b want v=1 y=32767 o=1",
                     bs.valid, $signed(bs.y), bs.overflow);
        end
        bs.x = -8'sd128; bs.coeffs = pk3(-300, 0, 0); bs.enable = 1'b1;
        tick();
        bs.enable = 1'b0;
        checks++;
        if (bs.valid !== 1'b0 || bs.overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_accept_clear got v=%b o=%b want v=0 o=0", bs.valid, bs.overflow);
        end
        n = 0;
        while (!bs.valid && n < 20) begin tick(); n++; end
        checks++;
        if (bs.y !== -16'sd32768 || bs.overflow !== 1'b1 || n !== 2) begin
            errors++;
            $display("FAIL sat_neg got y=%0d o=%b n=%0d want y=-32768 o=1 n=2",
                     $signed(bs.y), bs.overflow, n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bw.x = -8'sd4; bw.coeffs = pk3(1, 0, 0); bw.enable = 1'b1;
        tick();
        bw.enable = 1'b0;
        checks++;
        if (bw.overflow !== 1'b0 || bw.valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear got o=%b v=%b want o=0 v=0", bw.overflow, bw.valid);
        end
        n = 0;
        while (!bw.valid && n < 20) begin tick(); n++; end
        checks++;
        if (bw.y !== 16'sd16 || bw.overflow !== 1'b0 || n !== 2) begin
            errors++;
            $display("FAIL b2b_first got y=%0d o=%b n=%0d want y=16 o=0 n=2",
                     $signed(bw.y), bw.overflow, n);
        end
        bw.x = 8'sd0; bw.coeffs = pk3(1, 0, -9); bw.enable = 1'b1;
        tick();
        bw.enable = 1'b0;
        checks++;
        if (bw.valid !== 1'b0 || bw.ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reaccept got v=%b r=%b want v=0 r=0", bw.valid, bw.ready);
        end
        n = 0;
        while (!bw.valid && n < 20) begin tick(); n++; end
        checks++;
        if (bw.y !== -16'sd9 || n !== 2) begin
            errors++;
            $display("FAIL b2b_second got y=%0d n=%0d want y=-9 n=2", $signed(bw.y), n);
        end
        tick(); tick(); tick();
        checks++;
        if (bw.y !== -16'sd9 || bw.valid !== 1'b1 || bw.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold got y=%0d v=%b r=%b want y=-9 v=1 r=1",
                     $signed(bw.y), bw.valid, bw.ready);
        end
    endtask

    task automatic test_degree3();
        int n;
        b3.x = 8'sd2; b3.coeffs = pk4(1, -1, 3, -4); b3.enable = 1'b1;
        tick();
        b3.x = 8'sd7; b3.coeffs = pk4(5, 5, 5, 5);
        n = 0;
        while (!b3.valid && n < 20) begin tick(); n++; end
        b3.enable = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL d3_latency got %0d edges want 3", n);
        end
        checks++;
        if (b3.y !== 16'sd6 || b3.overflow !== 1'b0) begin
            errors++;
            $display("FAIL d3_result got y=%0d o=%b want y=6 o=0", $signed(b3.y), b3.overflow);
        end
        tick();
        checks++;
        if (b3.y !== 16'sd6 || b3.valid !== 1'b1) begin
            errors++;
            $display("FAIL d3_ignore_busy got y=%0d v=%b want y=6 v=1", $signed(b3.y), b3.valid);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        bw.x = 8'sd5; bw.coeffs = pk3(1, 1, 1); bw.enable = 1'b1;
        tick();
        bw.enable = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bw.y !== 16'sd0 || bw.valid !== 1'b0 || bw.ready !== 1'b1 || bw.overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_async got y=%0d v=%b r=%b o=%b want y=0 v=0 r=1 o=0",
                     $signed(bw.y), bw.valid, bw.ready, bw.overflow);
        end
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bw.valid !== 1'b0 || bw.y !== 16'sd0) begin
            errors++;
            $display("FAIL abort_no_valid got v=%b y=%0d want v=0 y=0", bw.valid, $signed(bw.y));
        end
        bw.enable = 1'b1;
        tick();
        bw.enable = 1'b0;
        n = 0;
        while (!bw.valid && n < 20) begin tick(); n++; end
        checks++;
        if (bw.y !== 16'sd31 || n !== 2 || bw.overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_rerun got y=%0d n=%0d o=%b want y=31 n=2 o=0",
                     $signed(bw.y), n, bw.overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_degree3();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly_horner_solver.md
Name: poly_horner_solver

Overview:
Parametrised successor to the fixed quadratic solver. Evaluates a signed polynomial y = sum(k_i * x^i), i = 0..DEGREE, using Horner's method with one multiplier, one step per clock. It uses the same enable/ready/valid handshake, so existing file-driven benches drive it unchanged. It adds a configurable degree, configurable widths, optional saturation, and a sticky overflow flag.

Parameters:
XW, 8, signed width of x.
CW, 16, signed width of each coefficient.
YW, 16, signed width of the accumulator and of y.
DEGREE, 2, polynomial degree. Legal values are 1 to 15. DEGREE=2 reproduces the quadratic solver: a=k2, b=k1, c=k0.
SATURATE, 0, overflow mode. 0 wraps two's-complement. 1 clamps to the YW signed range.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  start request. Sampled on a rising clock edge only while ready=1.
x  in  XW  signed input variable.
coeffs  in  (DEGREE+1)*CW  flat bus. coeffs[i*CW +: CW] is signed k_i, the coefficient of x^i.
y  out  YW  signed result. Held until the next result is produced.
ready  out  1  block idle; can accept enable.
valid  out  1  y holds the result of the most recent accepted request.
overflow  out  1  at least one Horner step of the current result overflowed YW. Qualified by valid.

Behaviour:
- Reset (async, active-high), applied immediately: state=IDLE, y=0, ready=1, valid=0, overflow=0, acc=0, step counter=0.
- States: IDLE, BUSY, DONE. ready=1 in IDLE and DONE; ready=0 in BUSY.
- Accept (IDLE or DONE, enable=1 at edge E):
  - latch x and all coefficients into internal registers;
  - acc <= k_DEGREE, sign-extended or clamped to YW;
  - cnt <= DEGREE-1;
  - valid <= 0, overflow <= 0, ready <= 0;
  - go to BUSY.
  - Inputs may change after E without affecting the computation.
- BUSY, each edge:
  - exact = acc*x + k_cnt, computed at YW+XW+1 bits with no loss;
  - overflow condition: exact lies outside [-2^(YW-1), 2^(YW-1)-1];
  - on overflow: acc <= low YW bits of exact (SATURATE=0) or the nearest bound (SATURATE=1), and the overflow flag is set sticky for this request;
  - cnt <= cnt-1.
- Completion (BUSY with cnt==0):
  - y <= final acc, valid <= 1, ready <= 1;
  - overflow output reflects the sticky flag;
  - go to DONE.
- Latency: valid and ready rise exactly DEGREE edges after acceptance edge E (E+2 for DEGREE=2). Throughput is one result per DEGREE+1 cycles at best.
- DONE: y, valid and overflow hold indefinitely until the next accepted enable. That edge clears valid and overflow in the same cycle.
- enable while BUSY: ignored. No queuing, no effect on the computation or outputs.
- enable held high across several edges: only the edge that sees ready=1 starts a computation. The next accept can happen only after completion.
- Reset asserted mid-BUSY: computation aborted, outputs return to their reset values. No valid pulse is produced for the aborted request.
- Initial k_DEGREE wider than YW (CW>YW): handled by the same wrap/clamp rule, and counts as overflow.

Test Plan:
- DEGREE=2, SATURATE=0; x=3, k2=2, k1=-5, k0=7; enable pulse -> valid and ready rise 2 edges after acceptance, y=10, overflow=0.
- DEGREE=2; x=-4, k2=1, k1=0, k0=0 -> y=16. Then immediately re-enable with x=0, k0=-9: valid drops at the accept edge, then y=-9.
- DEGREE=2, SATURATE=0; x=127, k2=100, k1=0, k0=0 -> step 1 gives 12700; step 2 exact 1612900 wraps; y=-25500, overflow=1.
- Same stimulus with SATURATE=1 -> y=32767, overflow=1. With x=-128, k2=-300 -> y=-32768, overflow=1.
- DEGREE=3; x=2, k3=1, k2=-1, k1=3, k0=-4 -> valid exactly 3 edges after acceptance, y=6. Re-pulse enable during BUSY with other data -> ignored, y still 6.
- Start x=5, k2=1, k1=1, k0=1; assert reset one cycle after acceptance -> y=0, valid=0, ready=1 immediately. After reset release, rerun the same request -> y=31.
